// File: rtl/mul_share_arb_pkg.sv
// mul_share_arb_pkg
//   Shared definitions for the multiplier-sharing arbiter:
//   - round-robin pointer reset value
//   - per-requester slot state encoding
//   - tag record carried alongside each multiplier operation
//   - corner_fix(): widens a sign-extended product and repairs the
//     most-negative x most-negative case that the multiplier cannot represent
package mul_share_arb_pkg;

    localparam int RR_PTR_RST = 0;
    localparam int IDW_MAX    = 3;     // up to 8 requesters
    localparam int PW_MAX     = 32;    // up to 16-bit operands

    typedef enum logic [1:0] {
        SLOT_IDLE     = 2'd0,
        SLOT_INFLIGHT = 2'd1,
        SLOT_DONE     = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic               valid;
        logic [IDW_MAX-1:0] id;
        logic               corner;
    } tag_t;

    // p_sext is the multiplier output already sign-extended to PW_MAX bits.
    // The only product that overflows 2W-1 bits is (-2^(W-1))^2 = 2^(2W-2).
    function automatic logic [PW_MAX-1:0] corner_fix(input logic [PW_MAX-1:0] p_sext,
                                                     input logic              corner,
                                                     input int unsigned       w);
        if (corner)
            corner_fix = PW_MAX'(1) << (2 * w - 2);
        else
            corner_fix = p_sext;
    endfunction

endpackage

// File: rtl/mul_rr_pick.sv
// mul_rr_pick
//   Combinational round-robin picker. Searches upward from ptr with
//   wrap-around and grants the first eligible requester.
// Ports:
//   eligible  : per-requester eligibility
//   ptr       : index where the search starts
//   grant     : one-hot grant (zero when nobody is eligible)
//   grant_idx : index of the granted requester (0 when none)
//   any_grant : a grant was made
module mul_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_grant
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!any_grant && eligible[idx]) begin
                any_grant      = 1'b1;
                grant_idx      = IDW'(idx);
                grant[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb
//   Shares one registered signed W x W multiplier (LAT cycles, 2W-1 bit
//   product) among NREQ requesters. Issues at most one operation per cycle
//   in round-robin order, tags each operation with its requester id, and
//   steers the returning product into that requester's one-entry result
//   buffer, widened to 2W bits with the most-negative-squared corner fixed.
//
//   Slot FSM (one per requester):
//     state         | meaning
//     SLOT_IDLE     | no operation outstanding, may be granted
//     SLOT_INFLIGHT | operation issued, tag travelling through the pipeline
//     SLOT_DONE     | result buffered, rsp_valid high until consumed
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : operand channel per requester (ready = grant)
//   req_a, req_b        : packed signed operands, W bits per requester
//   rsp_valid/rsp_ready : result channel per requester
//   rsp_p               : packed signed products, 2W bits per requester
//   mul_a, mul_b, mul_en: shared multiplier operands and enable
//   mul_p               : shared multiplier product (2W-1 bits)
module mul_share_arb
    import mul_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*W-1:0]  req_a,
    input  logic [NREQ*W-1:0]  req_b,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [NREQ*2*W-1:0] rsp_p,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    output logic               mul_en,
    input  logic [2*W-2:0]     mul_p
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = 2 * W;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    slot_state_e       slot_q [NREQ];
    slot_state_e       slot_d [NREQ];
    logic [PW-1:0]     rsp_q  [NREQ];
    tag_t              tag_q  [LAT+1];
    logic [IDW-1:0]    ptr_q;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic              any_grant;
    logic [W-1:0]      sel_a;
    logic [W-1:0]      sel_b;
    logic              sel_corner;
    logic              ret_valid;
    logic [IDW_MAX-1:0] ret_id;
    logic [PW_MAX-1:0] p_full;

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            eligible[i] = req_valid[i] && (slot_q[i] == SLOT_IDLE);
    end

    mul_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Slot registers clear asynchronously, but the picker is combinational,
    // so gate the handshake to keep req_ready low for the whole reset.
    assign req_ready = grant & ~{NREQ{rst}};

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
        sel_corner = (sel_a == MOST_NEG) && (sel_b == MOST_NEG);
    end

    // Stage 0 is aligned with the mul_a/mul_b register; the multiplier
    // captures those on the following edge, so the product is valid when
    // the tag reaches stage LAT.
    assign ret_valid = tag_q[LAT].valid;
    assign ret_id    = tag_q[LAT].id;
    assign p_full    = corner_fix(PW_MAX'($signed(mul_p)), tag_q[LAT].corner, W);

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            slot_d[i] = slot_q[i];
            case (slot_q[i])
                SLOT_IDLE:     if (grant[i]) slot_d[i] = SLOT_INFLIGHT;
                SLOT_INFLIGHT: if (ret_valid && ret_id == IDW_MAX'(i)) slot_d[i] = SLOT_DONE;
                SLOT_DONE:     if (rsp_ready[i]) slot_d[i] = SLOT_IDLE;
                default:       slot_d[i] = SLOT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i] <= SLOT_IDLE;
                rsp_q[i]  <= '0;
            end
            for (int k = 0; k <= LAT; k++)
                tag_q[k] <= '0;
            ptr_q  <= IDW'(RR_PTR_RST);
            mul_a  <= '0;
            mul_b  <= '0;
            mul_en <= 1'b0;
        end else begin
            mul_en <= 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i] <= slot_d[i];
                if (ret_valid && ret_id == IDW_MAX'(i))
                    rsp_q[i] <= PW'(p_full);
            end
            tag_q[0].valid  <= any_grant;
            tag_q[0].id     <= IDW_MAX'(grant_idx);
            tag_q[0].corner <= sel_corner;
            for (int k = 1; k <= LAT; k++)
                tag_q[k] <= tag_q[k-1];
            if (any_grant) begin
                mul_a <= sel_a;
                mul_b <= sel_b;
                if (grant_idx == IDW'(NREQ - 1))
                    ptr_q <= '0;
                else
                    ptr_q <= IDW'(grant_idx + 1'b1);
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_rsp
        assign rsp_valid[g]        = (slot_q[g] == SLOT_DONE);
        assign rsp_p[g*PW +: PW]   = rsp_q[g];
    end

endmodule
